// File: rtl/ram_wr_seq.sv
//------------------------------------------------------------------------------
// ram_wr_seq : fills one RAM frame of 2**ADDR_W words from a valid/ready
//              stream, then holds it for a reader until frame_ack.
// Optional   : define WR_FRAME_CNT_EN to add the 8-bit frame_cnt output.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_wr_seq #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] ram_d,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [ADDR_W:0]   fill_cnt,
   output logic              frame_rdy,
   input  logic              frame_ack
`ifdef WR_FRAME_CNT_EN
   ,
   output logic [7:0]        frame_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FILL     = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] c_last_ptr = '1;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_fill_cnt;
   logic                r_ram_we;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [DATA_W-1:0]   r_ram_d;
   logic                r_frame_rdy;
   logic                w_in_ready;
   logic                w_accept;
`ifdef WR_FRAME_CNT_EN
   logic [7:0]          r_frame_cnt;
`endif

   // abort masks ready so an abort cycle can never also accept a word
   assign w_in_ready = (r_state == ST_FILL) && !abort;
   assign w_accept   = in_valid && w_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_fill_cnt  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_d     <= '0;
         r_frame_rdy <= 1'b0;
`ifdef WR_FRAME_CNT_EN
         r_frame_cnt <= '0;
`endif
      end else begin
         r_ram_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_FILL;
                  r_ptr      <= '0;
                  r_fill_cnt <= '0;
               end
            end
            ST_FILL: begin
               if (abort) begin
                  r_state    <= ST_IDLE;
                  r_ptr      <= '0;
                  r_fill_cnt <= '0;
               end else if (w_accept) begin
                  r_ram_we   <= 1'b1;
                  r_ram_addr <= r_ptr;
                  r_ram_d    <= in_data;
                  r_ptr      <= r_ptr + 1'b1;
                  r_fill_cnt <= r_fill_cnt + 1'b1;
                  // last word: frame_rdy rises together with its write pulse
                  if (r_ptr == c_last_ptr) begin
                     r_state     <= ST_WAIT_ACK;
                     r_frame_rdy <= 1'b1;
                  end
               end
            end
            ST_WAIT_ACK: begin
               if (frame_ack) begin
                  r_state     <= ST_IDLE;
                  r_frame_rdy <= 1'b0;
                  r_fill_cnt  <= '0;
`ifdef WR_FRAME_CNT_EN
                  r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_d     = r_ram_d;
   assign fill_cnt  = r_fill_cnt;
   assign frame_rdy = r_frame_rdy;
`ifdef WR_FRAME_CNT_EN
   assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_wr_seq.sv
//------------------------------------------------------------------------------
// tb_ram_wr_seq : directed self-checking bench for ram_wr_seq.
// Revision      : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_wr_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] ram_d;
   logic [2:0] ram_addr;
   logic       ram_we;
   logic [3:0] fill_cnt;
   logic       frame_rdy;
   logic       frame_ack = 1'b0;
`ifdef WR_FRAME_CNT_EN
   logic [7:0] frame_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ram_wr_seq #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ram_d     (ram_d),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .fill_cnt  (fill_cnt),
      .frame_rdy (frame_rdy),
      .frame_ack (frame_ack)
`ifdef WR_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Fills a whole frame back to back; data = base + index.
   task automatic fill_frame(input string tag, input logic [7:0] base);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(i);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready[%0d]: got %b want 1", tag, i, in_ready);
         end
         tick();
         n_checks++;
         if (ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_d !== base + 8'(i)) begin
            n_fail++;
            $display("FAIL %s_write[%0d]: got we=%b addr=%0d d=%h want we=1 addr=%0d d=%h",
                     tag, i, ram_we, ram_addr, ram_d, i, base + 8'(i));
         end
         n_checks++;
         if (fill_cnt !== 4'(i + 1) || frame_rdy !== (i == 7)) begin
            n_fail++;
            $display("FAIL %s_cnt[%0d]: got fill_cnt=%0d frame_rdy=%b want %0d %b",
                     tag, i, fill_cnt, frame_rdy, i + 1, (i == 7));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic ack_frame(input string tag);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      n_checks++;
      if (frame_rdy !== 1'b0 || fill_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL %s_ack: got frame_rdy=%b fill_cnt=%0d want 0 0", tag, frame_rdy, fill_cnt);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({ram_we, ram_addr, ram_d, fill_cnt, frame_rdy, in_ready} !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b addr=%0d d=%h cnt=%0d rdy=%b ready=%b want all 0",
                  ram_we, ram_addr, ram_d, fill_cnt, frame_rdy, in_ready);
      end
      rst = 1'b0;
      tick();
      // no start yet: data must be refused
      in_valid = 1'b1;
      in_data  = 8'hEE;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (ram_we !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got we=%b ready=%b want 0 0", ram_we, in_ready);
      end
   endtask

   task automatic test_back_to_back;
      pulse_start();
      n_checks++;
      if (fill_cnt !== 4'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_start: got fill_cnt=%0d ready=%b want 0 1", fill_cnt, in_ready);
      end
      fill_frame("b2b", 8'h01);
   endtask

   task automatic test_wait_ack;
      in_valid = 1'b1;
      in_data  = 8'h55;
      start    = 1'b1;
      abort    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ready[%0d]: got %b want 0", i, in_ready);
         end
         tick();
         n_checks++;
         if (ram_we !== 1'b0 || frame_rdy !== 1'b1 || fill_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL wait_hold[%0d]: got we=%b rdy=%b cnt=%0d want 0 1 8",
                     i, ram_we, frame_rdy, fill_cnt);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      ack_frame("wait");
`ifdef WR_FRAME_CNT_EN
      n_checks++;
      if (frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL wait_frame_cnt: got %0d want 1", frame_cnt);
      end
`endif
      tick();
      n_checks++;
      if (ram_we !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle: got we=%b ready=%b want 0 0", ram_we, in_ready);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_abort;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h41 + 8'(i);
         tick();
      end
      in_data = 8'h44;
      abort   = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_ready: got %b want 0", in_ready);
      end
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (ram_we !== 1'b0 || fill_cnt !== 4'd0 || ram_addr !== 3'd2 || ram_d !== 8'h43) begin
         n_fail++;
         $display("FAIL abort_write: got we=%b cnt=%0d addr=%0d d=%h want 0 0 2 43",
                  ram_we, fill_cnt, ram_addr, ram_d);
      end
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: got ready=%b want 0", in_ready);
      end
      pulse_start();
      in_valid = 1'b1;
      in_data  = 8'hA0;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== 3'd0 || ram_d !== 8'hA0 || fill_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL abort_restart: got we=%b addr=%0d d=%h cnt=%0d want 1 0 a0 1",
                  ram_we, ram_addr, ram_d, fill_cnt);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_stall;
      int k;
      k = 0;
      pulse_start();
      for (int c = 0; c < 16; c++) begin
         in_valid = (c % 2 == 0);
         in_data  = 8'h10 + 8'(k);
         tick();
         if (c % 2 == 0) begin
            n_checks++;
            if (ram_we !== 1'b1 || ram_addr !== 3'(k) || ram_d !== 8'h10 + 8'(k)) begin
               n_fail++;
               $display("FAIL stall_write[%0d]: got we=%b addr=%0d d=%h want 1 %0d %h",
                        k, ram_we, ram_addr, ram_d, k, 8'h10 + 8'(k));
            end
            k++;
         end else begin
            n_checks++;
            if (ram_we !== 1'b0 || fill_cnt !== 4'(k) || ram_addr !== 3'(k - 1)) begin
               n_fail++;
               $display("FAIL stall_gap[%0d]: got we=%b cnt=%0d addr=%0d want 0 %0d %0d",
                        c, ram_we, fill_cnt, ram_addr, k, k - 1);
            end
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (frame_rdy !== 1'b1 || fill_cnt !== 4'd8) begin
         n_fail++;
         $display("FAIL stall_done: got rdy=%b cnt=%0d want 1 8", frame_rdy, fill_cnt);
      end
      ack_frame("stall");
   endtask

   task automatic test_async_reset;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h61 + 8'(i);
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({ram_we, ram_addr, ram_d, fill_cnt, frame_rdy, in_ready} !== 18'd0) begin
         n_fail++;
         $display("FAIL async_rst: got we=%b addr=%0d d=%h cnt=%0d rdy=%b ready=%b want all 0",
                  ram_we, ram_addr, ram_d, fill_cnt, frame_rdy, in_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      tick();
      n_checks++;
      if (ram_we !== 1'b0 || fill_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL async_nostart: got we=%b cnt=%0d want 0 0", ram_we, fill_cnt);
      end
      in_valid = 1'b0;
      pulse_start();
      fill_frame("async", 8'h30);
      ack_frame("async");
   endtask

`ifdef WR_FRAME_CNT_EN
   task automatic test_frame_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int f = 0; f < 257; f++) begin
         pulse_start();
         fill_frame("fcnt", 8'(f));
         ack_frame("fcnt");
         if (f == 255) begin
            n_checks++;
            if (frame_cnt !== 8'd0) begin
               n_fail++;
               $display("FAIL fcnt_wrap: got %0d want 0", frame_cnt);
            end
         end
      end
      n_checks++;
      if (frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL fcnt_257: got %0d want 1", frame_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_wait_ack();
      test_abort();
      test_stall();
      test_async_reset();
`ifdef WR_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ram_wr_seq.md
RAM_WR_SEQ -- requirements
Module: ram_wr_seq

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the data path and the RAM write word.
REQ-002 Parameter ADDR_W, default 3, SHALL set the RAM address width; frame length is 2**ADDR_W words (8).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin filling a frame.
REQ-006 abort  input  1  SHALL discard the frame being filled.
REQ-007 in_data  input  DATA_W  SHALL carry the upstream data word.
REQ-008 in_valid  input  1  SHALL mark in_data valid.
REQ-009 in_ready  output  1  SHALL signal that the block accepts a word this cycle.
REQ-010 ram_d  output  DATA_W  SHALL drive the RAM write data (d).
REQ-011 ram_addr  output  ADDR_W  SHALL drive the RAM write address (addr_in).
REQ-012 ram_we  output  1  SHALL drive the RAM write enable (we).
REQ-013 fill_cnt  output  ADDR_W+1  SHALL report the number of words accepted in the current frame, 0..8.
REQ-014 frame_rdy  output  1  SHALL indicate a complete frame is in RAM, ready for the reader.
REQ-015 frame_ack  input  1  SHALL be the reader's one-cycle release of a completed frame.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, FILL, WAIT_ACK.
REQ-017 IDLE -> FILL on start=1; write pointer and fill_cnt SHALL clear to 0 on that edge.
REQ-018 in_ready SHALL be 1 only in FILL and abort=0 (combinational from state and abort).
REQ-019 Accept SHALL be in_valid & in_ready; on each accept: pointer +1, fill_cnt +1.
REQ-020 ram_we, ram_addr, ram_d SHALL be registered: one cycle after an accept edge, ram_we=1, ram_addr=pointer at accept, ram_d=in_data at accept; otherwise ram_we=0 and ram_addr/ram_d hold.
REQ-021 Accepting with pointer=7 SHALL move FILL -> WAIT_ACK; pointer SHALL wrap to 0; fill_cnt SHALL read 8.
REQ-022 frame_rdy SHALL be registered and first assert in the same cycle as the 8th ram_we pulse; it SHALL stay 1 throughout WAIT_ACK.
REQ-023 WAIT_ACK -> IDLE on frame_ack=1; frame_rdy and fill_cnt SHALL clear on that edge.
REQ-024 abort=1 in FILL SHALL force IDLE, clear pointer and fill_cnt, and suppress any write that cycle (abort beats accept).
REQ-025 abort in IDLE or WAIT_ACK, start outside IDLE, and frame_ack outside WAIT_ACK SHALL be ignored.
REQ-026 in_valid gaps in FILL SHALL stall without loss; pointer and fill_cnt hold.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, pointer=0, fill_cnt=0, ram_we=0, ram_addr=0, ram_d=0, frame_rdy=0, in_ready=0.
REQ-028 Reset asserted mid-FILL or in WAIT_ACK SHALL discard the partial or complete frame; the first action after release SHALL require a new start.

Configuration
REQ-029 Macro WR_FRAME_CNT_EN defined: an extra output frame_cnt (8 bits, reset 0) SHALL increment by 1, wrapping 255 -> 0, on every WAIT_ACK -> IDLE transition.
REQ-030 Macro WR_FRAME_CNT_EN undefined: port frame_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, start, 8 back-to-back words 0x01..0x08 -> ram_we pulses at addr 0..7 with d 0x01..0x08, each one cycle after accept; frame_rdy=1 with the last; fill_cnt=8.
REQ-032 Frame full, in_valid held 1 with 0x55 -> in_ready=0, no ram_we, until frame_ack; after ack frame_rdy=0, state IDLE, fill_cnt=0.
REQ-033 Start, 3 words, abort in the same cycle as the 4th valid word -> 4th not written, fill_cnt=0, IDLE; next start refills from addr 0.
REQ-034 Start, words with in_valid toggling 1/0 -> 8 writes at addr 0..7 in order, none lost or duplicated.
REQ-035 rst asserted mid-cycle after 5 accepts -> all outputs 0 immediately, without waiting for a clk edge; start then 8 words writes addr 0..7.
REQ-036 With WR_FRAME_CNT_EN defined, 257 full frames, each acked -> frame_cnt=1.
